// File: rtl/goose_sprite_renderer.sv
// Goose sprite renderer: beam coords -> LUT x/y, palette -> RRGGBB, spin FSM.
// Optional BOUNCE_EN: sprite bounces off the active-area edges on frame_tick.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   hpos, vpos      : beam column/row
//   display_on      : active-video flag aligned with hpos/vpos
//   frame_tick      : one-cycle pulse at start of vertical blank
//   spin            : level request for the spin animation
//   lut_x, lut_y    : registered sprite-local coords to the bitmap LUT
//   frame_sel       : registered animation frame index to the LUT
//   lut_pixel       : palette index returned combinationally by the LUT
//   rgb             : registered RRGGBB pixel
//   busy            : animation FSM not idle
module goose_sprite_renderer #(
  parameter int         SCALE_LOG2 = 2,
  parameter int         POS_X      = 256,
  parameter int         POS_Y      = 176,
  parameter int         FRAME_HOLD = 6,
  parameter logic [5:0] BG_COLOR   = 6'b000001,
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter int         STEP       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       frame_tick,
  input  logic       spin,
  output logic [4:0] lut_x,
  output logic [4:0] lut_y,
  output logic [1:0] frame_sel,
  input  logic [2:0] lut_pixel,
  output logic [5:0] rgb,
  output logic       busy
);

  localparam int SPR_W = 32 << SCALE_LOG2;
  localparam int CW    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_HOLD - 1);
  localparam logic [10:0]   SPR_W11  = 11'(SPR_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPIN,
    S_SETTLE
  } state_e;

  // Sprite position
  logic [9:0] pos_x_q;
  logic [9:0] pos_y_q;

`ifdef BOUNCE_EN
  logic [9:0] pos_x_d;
  logic [9:0] pos_y_d;
  logic       dx_q, dx_d;  // 1 = moving +STEP
  logic       dy_q, dy_d;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (frame_tick) begin
      // An edge hit flips direction and skips the move for that tick
      if (dx_q) begin
        if (int'(pos_x_q) + SPR_W + STEP > H_ACTIVE) dx_d = 1'b0;
        else pos_x_d = pos_x_q + 10'(STEP);
      end else begin
        if (int'(pos_x_q) < STEP) dx_d = 1'b1;
        else pos_x_d = pos_x_q - 10'(STEP);
      end
      if (dy_q) begin
        if (int'(pos_y_q) + SPR_W + STEP > V_ACTIVE) dy_d = 1'b0;
        else pos_y_d = pos_y_q + 10'(STEP);
      end else begin
        if (int'(pos_y_q) < STEP) dy_d = 1'b1;
        else pos_y_d = pos_y_q - 10'(STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q <= 10'(POS_X);
      pos_y_q <= 10'(POS_Y);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end
`else
  localparam int unused_bounce = H_ACTIVE + V_ACTIVE + STEP;

  assign pos_x_q = 10'(POS_X);
  assign pos_y_q = 10'(POS_Y);
`endif

  // Stage 1: hit test and sprite-local coordinates
  logic [10:0] off_x;
  logic [10:0] off_y;
  logic        hit_x;
  logic        hit_y;
  logic        in_sprite_d;
  logic [4:0]  lut_x_d, lut_y_d;
  logic [4:0]  lut_x_q, lut_y_q;
  logic        in_sprite_q;
  logic        disp_q;

  always_comb begin
    off_x = {1'b0, hpos} - {1'b0, pos_x_q};
    off_y = {1'b0, vpos} - {1'b0, pos_y_q};
    hit_x = ({1'b0, hpos} >= {1'b0, pos_x_q})
         && ({1'b0, hpos} <  {1'b0, pos_x_q} + SPR_W11);
    hit_y = ({1'b0, vpos} >= {1'b0, pos_y_q})
         && ({1'b0, vpos} <  {1'b0, pos_y_q} + SPR_W11);
    in_sprite_d = hit_x && hit_y;
    lut_x_d = lut_x_q;
    lut_y_d = lut_y_q;
    if (in_sprite_d) begin
      lut_x_d = 5'(off_x >> SCALE_LOG2);
      lut_y_d = 5'(off_y >> SCALE_LOG2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_x_q     <= '0;
      lut_y_q     <= '0;
      in_sprite_q <= 1'b0;
      disp_q      <= 1'b0;
    end else begin
      lut_x_q     <= lut_x_d;
      lut_y_q     <= lut_y_d;
      in_sprite_q <= in_sprite_d;
      disp_q      <= display_on;
    end
  end

  assign lut_x = lut_x_q;
  assign lut_y = lut_y_q;

  // Stage 2: palette lookup and compositing
  logic [5:0] pal;
  logic [5:0] rgb_d, rgb_q;

  always_comb begin
    pal = 6'b000000;
    unique case (lut_pixel)
      3'd1:    pal = 6'b000000;
      3'd2:    pal = 6'b111111;
      3'd3:    pal = 6'b110100;
      3'd4:    pal = 6'b101010;
      3'd5:    pal = 6'b010101;
      3'd6:    pal = 6'b111100;
      3'd7:    pal = 6'b110111;
      default: pal = 6'b000000;
    endcase
  end

  always_comb begin
    rgb_d = pal;
    if (!disp_q)
      rgb_d = 6'b000000;
    else if (!in_sprite_q || lut_pixel == 3'd0)
      rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

  // Animation FSM
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      frame_q, frame_d;
  logic            wrap;
  logic [CW-1:0]   cnt_step;
  logic [1:0]      frame_step;

  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    cnt_step   = wrap ? '0 : cnt_q + 1'b1;
    frame_step = wrap ? frame_q + 2'd1 : frame_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        frame_d = '0;
        // The entry tick is the first counted tick
        if (frame_tick && spin) begin
          state_d = S_SPIN;
          cnt_d   = cnt_step;
          frame_d = frame_step;
        end
      end
      S_SPIN: begin
        if (frame_tick) begin
          cnt_d   = cnt_step;
          frame_d = frame_step;
          if (!spin) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (frame_tick) begin
          cnt_d   = cnt_step;
          frame_d = frame_step;
          if (spin)
            state_d = S_SPIN;
          else if (wrap && frame_q == 2'd3)
            state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame_sel = frame_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_goose_sprite_renderer.sv
// Directed testbench for goose_sprite_renderer (default parameters).
// Covers reset, pixel pipeline, palette, and the spin animation FSM.
module tb_goose_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_tick;
  logic       spin;
  logic [4:0] lut_x;
  logic [4:0] lut_y;
  logic [1:0] frame_sel;
  logic [2:0] lut_pixel;
  logic [5:0] rgb;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [5:0] BG = 6'b000001;

  goose_sprite_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .frame_tick (frame_tick),
    .spin       (spin),
    .lut_x      (lut_x),
    .lut_y      (lut_y),
    .frame_sel  (frame_sel),
    .lut_pixel  (lut_pixel),
    .rgb        (rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hpos = 10'd0;
    vpos = 10'd0;
    display_on = 1'b0;
    frame_tick = 1'b0;
    spin = 1'b0;
    lut_pixel = 3'd0;
    tick();
    tick();
    n_total++;
    if (lut_x !== 5'd0) $display("FAIL reset_lut_x got %0d want 0", lut_x);
    else n_pass++;
    n_total++;
    if (lut_y !== 5'd0) $display("FAIL reset_lut_y got %0d want 0", lut_y);
    else n_pass++;
    n_total++;
    if (frame_sel !== 2'd0) $display("FAIL reset_frame got %0d want 0", frame_sel);
    else n_pass++;
    n_total++;
    if (rgb !== 6'd0) $display("FAIL reset_rgb got %b want 000000", rgb);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    hpos = 10'd256;
    vpos = 10'd200;
    display_on = 1'b1;
    lut_pixel = 3'd3;
    tick();
    n_total++;
    if (lut_x !== 5'd0) $display("FAIL lat_lut_x got %0d want 0", lut_x);
    else n_pass++;
    n_total++;
    if (lut_y !== 5'd6) $display("FAIL lat_lut_y got %0d want 6", lut_y);
    else n_pass++;
    n_total++;
    if (rgb !== 6'd0) $display("FAIL lat_rgb_early got %b want 000000", rgb);
    else n_pass++;
    tick();
    n_total++;
    if (rgb !== 6'b110100) $display("FAIL lat_rgb got %b want 110100", rgb);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || frame_sel !== 2'd0)
      $display("FAIL lat_idle got busy=%b frame=%0d want 0/0", busy, frame_sel);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [9:0] hs [7];
    logic [4:0] ex [7];
    logic [5:0] er [7];
    hs = '{10'd300, 10'd255, 10'd256, 10'd259, 10'd260, 10'd383, 10'd384};
    ex = '{5'd11, 5'd11, 5'd0, 5'd0, 5'd1, 5'd31, 5'd31};
    er = '{6'b110100, BG, 6'b110100, 6'b110100, 6'b110100, 6'b110100, BG};
    vpos = 10'd200;
    display_on = 1'b1;
    lut_pixel = 3'd3;
    for (int i = 0; i < 7; i++) begin
      hpos = hs[i];
      tick();
      n_total++;
      if (lut_x !== ex[i])
        $display("FAIL sweep_lut_x h=%0d got %0d want %0d", hs[i], lut_x, ex[i]);
      else n_pass++;
      tick();
      n_total++;
      if (rgb !== er[i])
        $display("FAIL sweep_rgb h=%0d got %b want %b", hs[i], rgb, er[i]);
      else n_pass++;
    end
  endtask

  task automatic test_palette();
    logic [5:0] pe [8];
    pe = '{6'b000001, 6'b000000, 6'b111111, 6'b110100,
           6'b101010, 6'b010101, 6'b111100, 6'b110111};
    hpos = 10'd280;
    vpos = 10'd200;
    display_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lut_pixel = 3'(i);
      tick();
      tick();
      n_total++;
      if (rgb !== pe[i])
        $display("FAIL palette idx=%0d got %b want %b", i, rgb, pe[i]);
      else n_pass++;
    end
    display_on = 1'b0;
    lut_pixel = 3'd3;
    tick();
    tick();
    n_total++;
    if (rgb !== 6'd0) $display("FAIL blank_rgb got %b want 000000", rgb);
    else n_pass++;
    display_on = 1'b1;
  endtask

  task automatic chk_anim(input string nm, input logic [1:0] f,
                          input logic b);
    n_total++;
    if (frame_sel !== f || busy !== b)
      $display("FAIL %s got frame=%0d busy=%b want frame=%0d busy=%b",
               nm, frame_sel, busy, f, b);
    else n_pass++;
  endtask

  task automatic test_spin();
    spin = 1'b0;
    pulse(3);
    chk_anim("idle_no_spin", 2'd0, 1'b0);
    spin = 1'b1;
    pulse(5);
    chk_anim("spin_5", 2'd0, 1'b1);
    tick();
    tick();
    chk_anim("spin_no_tick", 2'd0, 1'b1);
    pulse(1);
    chk_anim("spin_6", 2'd1, 1'b1);
    pulse(6);
    chk_anim("spin_12", 2'd2, 1'b1);
    pulse(12);
    chk_anim("spin_24", 2'd0, 1'b1);
  endtask

  task automatic test_settle();
    pulse(12);
    chk_anim("pre_settle", 2'd2, 1'b1);
    spin = 1'b0;
    pulse(6);
    chk_anim("settle_f3", 2'd3, 1'b1);
    spin = 1'b1;
    pulse(6);
    chk_anim("resume_wrap", 2'd0, 1'b1);
    spin = 1'b0;
    pulse(6);
    chk_anim("settle_f1", 2'd1, 1'b1);
    pulse(17);
    chk_anim("settle_f3b", 2'd3, 1'b1);
    pulse(1);
    chk_anim("settle_idle", 2'd0, 1'b0);
    pulse(2);
    chk_anim("idle_stays", 2'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    spin = 1'b1;
    pulse(6);
    chk_anim("mid_f1", 2'd1, 1'b1);
    rst = 1'b1;
    frame_tick = 1'b1;
    tick();
    rst = 1'b0;
    frame_tick = 1'b0;
    chk_anim("mid_reset", 2'd0, 1'b0);
    pulse(5);
    chk_anim("post_rst_5", 2'd0, 1'b1);
    pulse(1);
    chk_anim("post_rst_6", 2'd1, 1'b1);
    spin = 1'b0;
  endtask

`ifndef BOUNCE_EN
  task automatic test_fixed_pos();
    display_on = 1'b1;
    lut_pixel = 3'd2;
    vpos = 10'd176;
    hpos = 10'd256;
    tick();
    tick();
    n_total++;
    if (lut_x !== 5'd0 || lut_y !== 5'd0 || rgb !== 6'b111111)
      $display("FAIL fixed_pos got x=%0d y=%0d rgb=%b want 0 0 111111",
               lut_x, lut_y, rgb);
    else n_pass++;
    vpos = 10'd175;
    tick();
    tick();
    n_total++;
    if (rgb !== BG) $display("FAIL fixed_above got %b want %b", rgb, BG);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_sweep();
    test_palette();
    test_spin();
    test_settle();
    test_reset_mid();
`ifndef BOUNCE_EN
    test_fixed_pos();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
